dmi_uart_link: RTL and testbench

Byte-framing link layer between the UART PHY (rx/tx byte engines) and `DMI_UART_TAP_ASYNC`. Its RX path strips escape framing from the incoming byte stream and buffers each byte with a command flag in a FIFO. That FIFO directly drives the TAP's `DATA_REC_I`, `CMD_REC_I` and `RX_EMPTY_I` inputs and is popped by the TAP's `READ_O`. Its TX path accepts data bytes and command bytes from the TAP and emits them to the PHY with escape insertion.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/dmi_uart_link_if.sv | 41 ++++
 rtl/uart_sync_fifo.sv | 52 +++++
 rtl/dmi_uart_link.sv | 141 ++++++++++++++
 tb/tb_dmi_uart_link.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART link definitions: escape byte, TX sequencer states, RX entry layout.
package uart_pkg;

  localparam logic [7:0] ESC_BYTE = 8'h1B;

  typedef enum logic [2:0] {
    LINK_IDLE,
    LINK_ESC,
    LINK_ESC_GAP,
    LINK_BYTE,
    LINK_BYTE_GAP
  } link_tx_state_t;

  // One decoded RX byte: cmd marks a byte that followed a single escape.
  typedef struct packed {
    logic       cmd;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/dmi_uart_link_if.sv
// Signal bundle between the framing link, the UART PHY and the DMI TAP.
// slave is the link's view; master is the view of the PHY + TAP around it.
interface dmi_uart_link_if;

  logic       PHY_RX_VALID_I;
  logic [7:0] PHY_RX_DATA_I;
  logic       PHY_TX_READY_I;
  logic       PHY_TX_VALID_O;
  logic [7:0] PHY_TX_DATA_O;

  logic       READ_I;
  logic [7:0] DATA_REC_O;
  logic       CMD_REC_O;
  logic       RX_EMPTY_O;
  logic       RX_OVERFLOW_O;

  logic       WRITE_I;
  logic [7:0] DATA_SEND_I;
  logic       SEND_COMMAND_I;
  logic [7:0] COMMAND_I;
  logic       TX_READY_O;

  modport slave (
    input  PHY_RX_VALID_I, PHY_RX_DATA_I, PHY_TX_READY_I,
    output PHY_TX_VALID_O, PHY_TX_DATA_O,
    input  READ_I,
    output DATA_REC_O, CMD_REC_O, RX_EMPTY_O, RX_OVERFLOW_O,
    input  WRITE_I, DATA_SEND_I, SEND_COMMAND_I, COMMAND_I,
    output TX_READY_O
  );

  modport master (
    output PHY_RX_VALID_I, PHY_RX_DATA_I, PHY_TX_READY_I,
    input  PHY_TX_VALID_O, PHY_TX_DATA_O,
    output READ_I,
    input  DATA_REC_O, CMD_REC_O, RX_EMPTY_O, RX_OVERFLOW_O,
    output WRITE_I, DATA_SEND_I, SEND_COMMAND_I, COMMAND_I,
    input  TX_READY_O
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. DEPTH must be a power of two so
// the pointers wrap naturally. head reads zero while the FIFO is empty.
module uart_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // A pop on an empty FIFO is ignored; a pop frees the slot a full-FIFO push needs.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge CLK_I) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dmi_uart_link.sv
// Byte-framing link between the UART PHY and the DMI TAP.
// RX: ESC x -> command x, ESC ESC -> literal ESC, other bytes pass as data.
// TX: data bytes equal to ESC and all command bytes go out prefixed with ESC.
module dmi_uart_link
  import uart_pkg::*;
#(
  parameter int         RX_DEPTH = 8,
  parameter logic [7:0] ESC      = ESC_BYTE
) (
  input logic            CLK_I,
  input logic            RST_I,
  dmi_uart_link_if.slave link
);

  logic           esc_pending;
  logic           rx_push;
  rx_entry_t      rx_entry;
  rx_entry_t      rx_head;
  logic           rx_full;
  logic           rx_empty;
  logic           rx_overflow;

  link_tx_state_t tx_state;
  logic [7:0]     tx_byte;
  logic           byte_gap_left;
  logic           tx_valid;
  logic [7:0]     tx_data;

  // Escape decode of the incoming PHY byte into a FIFO push request.
  always_comb begin
    rx_push  = 1'b0;
    rx_entry = '0;
    if (link.PHY_RX_VALID_I) begin
      if (esc_pending) begin
        rx_push       = 1'b1;
        rx_entry.cmd  = (link.PHY_RX_DATA_I != ESC);
        rx_entry.data = link.PHY_RX_DATA_I;
      end else if (link.PHY_RX_DATA_I != ESC) begin
        rx_push       = 1'b1;
        rx_entry.data = link.PHY_RX_DATA_I;
      end
    end
  end

  // Escape-pending flag: set by a lone ESC, cleared by whatever follows it.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      esc_pending <= 1'b0;
    end else if (link.PHY_RX_VALID_I) begin
      esc_pending <= !esc_pending && (link.PHY_RX_DATA_I == ESC);
    end
  end

  // Sticky overflow: a decoded byte arrived while full with no pop to make room.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rx_overflow <= 1'b0;
    end else if (rx_push && rx_full && !link.READ_I) begin
      rx_overflow <= 1'b1;
    end
  end

  uart_sync_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .CLK_I     (CLK_I),
    .RST_I     (RST_I),
    .push      (rx_push),
    .push_data (rx_entry),
    .pop       (link.READ_I),
    .full      (rx_full),
    .empty     (rx_empty),
    .head      (rx_head)
  );

  assign link.DATA_REC_O    = rx_head.data;
  assign link.CMD_REC_O     = rx_head.cmd;
  assign link.RX_EMPTY_O    = rx_empty;
  assign link.RX_OVERFLOW_O = rx_overflow;

  // TX sequencer: latch a request, emit optional ESC prefix, then the byte.
  // BYTE_GAP spans two cycles so TX_READY_O returns two cycles after the
  // final byte strobe; ESC_GAP only has to skip the cycle the PHY is still
  // reporting ready for the byte it just took.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      tx_state      <= LINK_IDLE;
      tx_byte       <= '0;
      byte_gap_left <= 1'b0;
      tx_valid      <= 1'b0;
      tx_data       <= '0;
    end else begin
      tx_valid <= 1'b0;
      case (tx_state)
        LINK_IDLE: begin
          if (link.SEND_COMMAND_I) begin
            tx_byte  <= link.COMMAND_I;
            tx_state <= LINK_ESC;
          end else if (link.WRITE_I) begin
            tx_byte  <= link.DATA_SEND_I;
            tx_state <= (link.DATA_SEND_I == ESC) ? LINK_ESC : LINK_BYTE;
          end
        end
        LINK_ESC: begin
          if (link.PHY_TX_READY_I) begin
            tx_valid <= 1'b1;
            tx_data  <= ESC;
            tx_state <= LINK_ESC_GAP;
          end
        end
        LINK_ESC_GAP: begin
          tx_state <= LINK_BYTE;
        end
        LINK_BYTE: begin
          if (link.PHY_TX_READY_I) begin
            tx_valid      <= 1'b1;
            tx_data       <= tx_byte;
            byte_gap_left <= 1'b1;
            tx_state      <= LINK_BYTE_GAP;
          end
        end
        LINK_BYTE_GAP: begin
          if (byte_gap_left) begin
            byte_gap_left <= 1'b0;
          end else begin
            tx_state <= LINK_IDLE;
          end
        end
        default: begin
          tx_state <= LINK_IDLE;
        end
      endcase
    end
  end

  assign link.TX_READY_O     = (tx_state == LINK_IDLE);
  assign link.PHY_TX_VALID_O = tx_valid;
  assign link.PHY_TX_DATA_O  = tx_data;

endmodule

// File: tb/tb_dmi_uart_link.sv
// Bench for dmi_uart_link: queue-based RX/TX reference model checked every
// cycle, directed scenarios with hand-computed literals, then random traffic.
`timescale 1ns/1ps
module tb_dmi_uart_link;
  import uart_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmi_uart_link_if lif();

  dmi_uart_link #(.RX_DEPTH(DEPTH), .ESC(ESC_BYTE)) dut (
    .CLK_I (clk),
    .RST_I (rst),
    .link  (lif)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model state
  logic [8:0] rxq[$];
  bit         m_esc = 0;
  bit         m_ovf = 0;
  logic [7:0] txq[$];
  int         tx_elig = 0;
  int         tx_ready_at = 0;
  bit         exp_valid = 0;
  logic [7:0] exp_data = 8'h00;

  // PHY behaviour and strobe log
  int         phy_hold = 0;
  int         frame_len = 0;
  bit         rand_frames = 0;
  bit         saw_strobe = 0;
  int         st_cyc[$];
  logic [7:0] st_dat[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_idle(input int k);
    return (txq.size() == 0) && (k >= tx_ready_at);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: advances once per cycle from the inputs of that cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rxq.delete();
      txq.delete();
      m_esc = 0;
      m_ovf = 0;
      tx_elig = 0;
      tx_ready_at = 0;
      exp_valid = 0;
      exp_data = 8'h00;
    end else begin
      int k;
      int sz;
      bit popped;
      logic [7:0] b;
      k = cyc;
      sz = rxq.size();
      popped = lif.READ_I && (sz > 0);
      if (popped) void'(rxq.pop_front());
      if (lif.PHY_RX_VALID_I) begin
        b = lif.PHY_RX_DATA_I;
        if (!m_esc && b == ESC_BYTE) begin
          m_esc = 1;
        end else begin
          if (sz < DEPTH || popped) rxq.push_back({m_esc && (b != ESC_BYTE), b});
          else m_ovf = 1;
          m_esc = 0;
        end
      end
      exp_valid = 0;
      if (txq.size() > 0) begin
        if (k >= tx_elig && lif.PHY_TX_READY_I) begin
          exp_valid = 1;
          exp_data = txq.pop_front();
          tx_elig = k + 2;
          if (txq.size() == 0) tx_ready_at = k + 3;
        end
      end else if (k >= tx_ready_at) begin
        if (lif.SEND_COMMAND_I) begin
          txq.push_back(ESC_BYTE);
          txq.push_back(lif.COMMAND_I);
          tx_elig = k + 1;
        end else if (lif.WRITE_I) begin
          if (lif.DATA_SEND_I == ESC_BYTE) txq.push_back(ESC_BYTE);
          txq.push_back(lif.DATA_SEND_I);
          tx_elig = k + 1;
        end
      end
    end
  end

  // Compare DUT against the model mid-cycle, and log PHY strobes.
  always @(negedge clk) begin
    logic [7:0] eh;
    logic       ec;
    saw_strobe = lif.PHY_TX_VALID_O;
    if (lif.PHY_TX_VALID_O === 1'b1) begin
      st_cyc.push_back(cyc);
      st_dat.push_back(lif.PHY_TX_DATA_O);
    end
    eh = 8'h00;
    ec = 1'b0;
    if (rxq.size() > 0) begin
      eh = rxq[0][7:0];
      ec = rxq[0][8];
    end
    check("rx_empty", lif.RX_EMPTY_O, rxq.size() == 0);
    check("data_rec", lif.DATA_REC_O, eh);
    check("cmd_rec", lif.CMD_REC_O, ec);
    check("rx_overflow", lif.RX_OVERFLOW_O, m_ovf);
    check("tx_ready", lif.TX_READY_O, m_idle(cyc));
    check("phy_tx_valid", lif.PHY_TX_VALID_O, exp_valid);
    if (exp_valid) check("phy_tx_data", lif.PHY_TX_DATA_O, exp_data);
    if (rst) check("phy_tx_data_rst", lif.PHY_TX_DATA_O, 8'h00);
  end

  // PHY transmitter: after accepting a byte, ready drops for a frame.
  always @(posedge clk) begin
    #1;
    if (saw_strobe) phy_hold = rand_frames ? $urandom_range(0, 6) : frame_len;
    if (phy_hold > 0) begin
      lif.PHY_TX_READY_I = 1'b0;
      phy_hold--;
    end else begin
      lif.PHY_TX_READY_I = 1'b1;
    end
  end

  task automatic clear_inputs();
    lif.PHY_RX_VALID_I = 1'b0;
    lif.PHY_RX_DATA_I  = 8'h00;
    lif.READ_I         = 1'b0;
    lif.WRITE_I        = 1'b0;
    lif.DATA_SEND_I    = 8'h00;
    lif.SEND_COMMAND_I = 1'b0;
    lif.COMMAND_I      = 8'h00;
  endtask

  initial begin
    int r;
    int n;
    logic [7:0] exp_b;
    clear_inputs();

    // reset values
    repeat (2) @(negedge clk);
    check("rst_rx_empty", lif.RX_EMPTY_O, 1);
    check("rst_tx_ready", lif.TX_READY_O, 1);
    check("rst_phy_valid", lif.PHY_TX_VALID_O, 0);
    check("rst_overflow", lif.RX_OVERFLOW_O, 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // 11, ESC, 22 -> {0,11}, {1,22}
    lif.PHY_RX_VALID_I = 1'b1;
    lif.PHY_RX_DATA_I  = 8'h11;
    @(negedge clk);
    check("rx_lat_same_cycle", lif.RX_EMPTY_O, 1);
    tick();
    lif.PHY_RX_DATA_I = 8'h1B;
    @(negedge clk);
    check("rx_lat_next_cycle", lif.RX_EMPTY_O, 0);
    check("rx_head_11", lif.DATA_REC_O, 8'h11);
    tick();
    lif.PHY_RX_DATA_I = 8'h22;
    tick();
    lif.PHY_RX_VALID_I = 1'b0;
    lif.READ_I = 1'b1;
    tick();
    lif.READ_I = 1'b0;
    @(negedge clk);
    check("rx_head_22", lif.DATA_REC_O, 8'h22);
    check("rx_cmd_22", lif.CMD_REC_O, 1);
    tick();
    lif.READ_I = 1'b1;
    tick();
    lif.READ_I = 1'b0;
    @(negedge clk);
    check("rx_drained", lif.RX_EMPTY_O, 1);

    // ESC ESC -> literal ESC
    tick();
    lif.PHY_RX_VALID_I = 1'b1;
    lif.PHY_RX_DATA_I  = 8'h1B;
    tick();
    tick();
    lif.PHY_RX_VALID_I = 1'b0;
    @(negedge clk);
    check("lit_esc_data", lif.DATA_REC_O, 8'h1B);
    check("lit_esc_cmd", lif.CMD_REC_O, 0);
    tick();
    lif.READ_I = 1'b1;
    tick();
    lif.READ_I = 1'b0;

    // nine bytes into eight slots, then push+pop while full
    for (int i = 0; i < 9; i++) begin
      lif.PHY_RX_VALID_I = 1'b1;
      lif.PHY_RX_DATA_I  = 8'h40 + 8'(i);
      tick();
    end
    lif.PHY_RX_VALID_I = 1'b0;
    @(negedge clk);
    check("ovf_set", lif.RX_OVERFLOW_O, 1);
    check("ovf_head", lif.DATA_REC_O, 8'h40);
    tick();
    lif.PHY_RX_VALID_I = 1'b1;
    lif.PHY_RX_DATA_I  = 8'h50;
    lif.READ_I         = 1'b1;
    tick();
    lif.PHY_RX_VALID_I = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (lif.RX_EMPTY_O) break;
      exp_b = (n < 7) ? (8'h41 + 8'(n)) : 8'h50;
      check("drain_byte", lif.DATA_REC_O, exp_b);
      n++;
      tick();
    end
    lif.READ_I = 1'b0;
    check("drain_count", n, 8);
    check("ovf_sticky", lif.RX_OVERFLOW_O, 1);

    // plain byte, PHY idle
    frame_len = 0;
    repeat (3) tick();
    st_cyc.delete();
    st_dat.delete();
    lif.WRITE_I = 1'b1;
    lif.DATA_SEND_I = 8'hA5;
    r = cyc;
    tick();
    lif.WRITE_I = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      check("a5_tx_ready", lif.TX_READY_O, (j == 4));
    end
    repeat (3) tick();
    check("a5_strobes", st_cyc.size(), 1);
    if (st_cyc.size() == 1) begin
      check("a5_strobe_cycle", st_cyc[0] - r, 2);
      check("a5_strobe_data", st_dat[0], 8'hA5);
    end

    // command beats write; PHY ready low 10 cycles before each byte
    frame_len = 10;
    @(negedge clk);
    phy_hold = 10;
    tick();
    st_cyc.delete();
    st_dat.delete();
    lif.SEND_COMMAND_I = 1'b1;
    lif.COMMAND_I = 8'h04;
    lif.WRITE_I = 1'b1;
    lif.DATA_SEND_I = 8'h55;
    r = cyc;
    tick();
    clear_inputs();
    for (int i = 0; i < 80 && st_cyc.size() < 2; i++) tick();
    repeat (15) tick();
    check("cmd_strobes", st_cyc.size(), 2);
    if (st_cyc.size() == 2) begin
      check("cmd_esc_data", st_dat[0], 8'h1B);
      check("cmd_byte_data", st_dat[1], 8'h04);
      check("cmd_esc_cycle", st_cyc[0] - r, 11);
      check("cmd_byte_cycle", st_cyc[1] - r, 23);
    end

    // reset between ESC and command byte strobes
    frame_len = 3;
    repeat (3) tick();
    st_cyc.delete();
    st_dat.delete();
    lif.SEND_COMMAND_I = 1'b1;
    lif.COMMAND_I = 8'h07;
    tick();
    clear_inputs();
    lif.PHY_RX_VALID_I = 1'b1;
    lif.PHY_RX_DATA_I = 8'h1B;
    tick();
    lif.PHY_RX_VALID_I = 1'b0;
    for (int i = 0; i < 40 && st_cyc.size() < 1; i++) tick();
    check("rst_mid_esc_seen", st_cyc.size(), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    check("rst_mid_no_more", st_cyc.size(), 1);
    @(negedge clk);
    check("rst_mid_tx_ready", lif.TX_READY_O, 1);
    check("rst_mid_rx_empty", lif.RX_EMPTY_O, 1);
    tick();
    lif.PHY_RX_VALID_I = 1'b1;
    lif.PHY_RX_DATA_I = 8'h33;
    tick();
    lif.PHY_RX_VALID_I = 1'b0;
    @(negedge clk);
    check("rst_mid_33_data", lif.DATA_REC_O, 8'h33);
    check("rst_mid_33_cmd", lif.CMD_REC_O, 0);
    tick();
    lif.READ_I = 1'b1;
    tick();
    lif.READ_I = 1'b0;

    // random traffic with varying PHY frame lengths
    rand_frames = 1;
    for (int i = 0; i < 3000; i++) begin
      lif.PHY_RX_VALID_I = ($urandom_range(0, 9) < 4);
      lif.PHY_RX_DATA_I  = ($urandom_range(0, 3) == 0) ? ESC_BYTE : 8'($urandom);
      lif.READ_I         = ($urandom_range(0, 9) < 3);
      lif.WRITE_I        = ($urandom_range(0, 9) == 0);
      lif.DATA_SEND_I    = ($urandom_range(0, 4) == 0) ? ESC_BYTE : 8'($urandom);
      lif.SEND_COMMAND_I = ($urandom_range(0, 19) == 0);
      lif.COMMAND_I      = 8'($urandom);
      tick();
    end
    clear_inputs();
    repeat (40) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
